instr_aligner: RTL and testbench

- Fetch-side stage directly upstream of the compressed-instruction decoder.
- Buffers word-aligned 32-bit fetch responses in a small FIFO.
- Extracts one instruction per handshake: either a 16-bit compressed halfword or a full 32-bit instruction, including 32-bit instructions split across two fetch words.
- Delivers the raw instruction and its PC to decode; decode performs decompression.

---
 rtl/if_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/instr_aligner.sv | 211 +++++++++++++++++++++
 tb/tb_instr_aligner.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction aligner and its fetch FIFO.
// Optional build macro: INSTR_ALIGNER_ERR_EN adds a per-word error bit to fetch entries.
package if_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;

    // Low two bits of a halfword that mark the start of a 32-bit instruction.
    localparam logic [1:0] OPC_32B = 2'b11;

    typedef enum logic [1:0] {
        S_ALIGNED = 2'd0,
        S_HALF    = 2'd1,
        S_SPLIT   = 2'd2
    } align_state_e;

    typedef struct packed {
        logic [31:0]             rdata;
        logic [FETCH_ADDR_W-1:2] addr;
`ifdef INSTR_ALIGNER_ERR_EN
        logic                    err;
`endif
    } fetch_entry_t;

    // True when the halfword starts a 32-bit instruction.
    function automatic logic is_32b(input logic [15:0] hw);
        return hw[1:0] == OPC_32B;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of word-aligned fetch responses.
// Ports: clk_i/rst_i (async active-high), flush_i empties the FIFO,
//        push_i/wdata_i write side, pop_i/head_o read side, full_o/empty_o status.
// Push is ignored when full or flushing; pop is ignored when empty or flushing.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t wdata_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem[rptr_q];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry storage; contents are only observed while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_aligner.sv
// Fetch-side aligner: extracts 16-bit compressed or 32-bit instructions
// (including ones split across two fetch words) from buffered fetch responses.
// Ports:
//   clk_i, rst_i (async active-high)
//   flush_i, flush_addr_i          redirect; bit 1 of the new PC selects the start halfword
//   fetch_valid_i/fetch_ready_o, fetch_rdata_i, fetch_addr_i   fetch response in
//   instr_valid_o/instr_ready_i, instr_o, instr_addr_o          instruction out to decode
// Optional build macro INSTR_ALIGNER_ERR_EN adds fetch_err_i and instr_err_o;
// an errored instruction is still length-decoded but presented as zero.
module instr_aligner
    import if_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_addr_i,
    input  logic              fetch_valid_i,
    output logic              fetch_ready_o,
    input  logic [31:0]       fetch_rdata_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
`ifdef INSTR_ALIGNER_ERR_EN
    input  logic              fetch_err_i,
    output logic              instr_err_o,
`endif
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] instr_addr_o
);

    if (ADDR_W != FETCH_ADDR_W) begin : g_addr_w_check
        $error("instr_aligner: ADDR_W must match if_pkg::FETCH_ADDR_W");
    end

    align_state_e      state_q;
    align_state_e      state_n;
    logic [15:0]       hold_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic              hold_err_q;

    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              hold_load;
    logic              head_err;

    logic              valid_c;
    logic [31:0]       instr_c;
    logic [ADDR_W-1:0] addr_c;
    logic              err_c;

    logic [31:0]       w;
    logic [ADDR_W-1:0] head_addr;
    logic              unused_bits;

    // Only bit 1 of the flush address and the word part of the fetch address carry information.
    assign unused_bits = ^{flush_addr_i[ADDR_W-1:2], flush_addr_i[0], fetch_addr_i[1:0]};

    assign fetch_ready_o = !fifo_full;
    assign push          = fetch_valid_i && !fifo_full && !flush_i;

    assign push_entry.rdata = fetch_rdata_i;
    assign push_entry.addr  = fetch_addr_i[ADDR_W-1:2];
`ifdef INSTR_ALIGNER_ERR_EN
    assign push_entry.err   = fetch_err_i;
    assign head_err         = head.err;
`else
    assign head_err         = 1'b0;
`endif

    assign w         = head.rdata;
    assign head_addr = {head.addr, 2'b00};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State and hold register; flush clears the hold and picks the start halfword.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_ALIGNED;
            hold_q      <= '0;
            hold_addr_q <= '0;
        end else begin
            state_q <= state_n;
            if (flush_i) begin
                hold_q      <= '0;
                hold_addr_q <= '0;
            end else if (hold_load) begin
                hold_q      <= w[31:16];
                hold_addr_q <= {head.addr, 2'b10};
            end
        end
    end

`ifdef INSTR_ALIGNER_ERR_EN
    // Error bit travelling with the held upper halfword.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_err_q <= 1'b0;
        end else if (flush_i) begin
            hold_err_q <= 1'b0;
        end else if (hold_load) begin
            hold_err_q <= head_err;
        end
    end
`else
    assign hold_err_q = 1'b0;
`endif

    // Next-state, FIFO pop and instruction extraction.
    always_comb begin
        state_n   = state_q;
        pop       = 1'b0;
        hold_load = 1'b0;
        valid_c   = 1'b0;
        instr_c   = 32'h0;
        addr_c    = '0;
        err_c     = 1'b0;

        case (state_q)
            S_ALIGNED: begin
                if (!fifo_empty) begin
                    valid_c = 1'b1;
                    addr_c  = head_addr;
                    err_c   = head_err;
                    if (!is_32b(w[15:0])) begin
                        instr_c = {16'h0, w[15:0]};
                        if (instr_ready_i) begin
                            state_n = S_HALF;
                        end
                    end else begin
                        instr_c = w;
                        if (instr_ready_i) begin
                            pop = 1'b1;
                        end
                    end
                end
            end
            S_HALF: begin
                if (!fifo_empty) begin
                    if (!is_32b(w[31:16])) begin
                        valid_c = 1'b1;
                        instr_c = {16'h0, w[31:16]};
                        addr_c  = {head.addr, 2'b10};
                        err_c   = head_err;
                        if (instr_ready_i) begin
                            pop     = 1'b1;
                            state_n = S_ALIGNED;
                        end
                    end else begin
                        // Upper half starts a 32-bit instruction: park it and wait for the next word.
                        hold_load = 1'b1;
                        pop       = 1'b1;
                        state_n   = S_SPLIT;
                    end
                end
            end
            S_SPLIT: begin
                if (!fifo_empty) begin
                    valid_c = 1'b1;
                    instr_c = {w[15:0], hold_q};
                    addr_c  = hold_addr_q;
                    err_c   = hold_err_q | head_err;
                    if (instr_ready_i) begin
                        state_n = S_HALF;
                    end
                end
            end
            default: begin
                state_n = S_ALIGNED;
            end
        endcase

        if (err_c) begin
            instr_c = 32'h0;
        end

        // Redirect overrides everything else in its cycle.
        if (flush_i) begin
            valid_c   = 1'b0;
            pop       = 1'b0;
            hold_load = 1'b0;
            state_n   = flush_addr_i[1] ? S_HALF : S_ALIGNED;
        end
    end

    assign instr_valid_o = valid_c;
    assign instr_o       = instr_c;
    assign instr_addr_o  = addr_c;
`ifdef INSTR_ALIGNER_ERR_EN
    assign instr_err_o   = valid_c & err_c;
`endif

endmodule

// File: tb/tb_instr_aligner.sv
// Testbench for instr_aligner: directed scenarios plus a randomized run checked
// against a halfword-stream reference model.
module tb_instr_aligner;

`ifdef INSTR_ALIGNER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] flush_addr_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_err;

    always #5 clk = ~clk;

    instr_aligner #(
        .DEPTH  (2),
        .ADDR_W (32)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_rdata_i (fetch_rdata_i),
        .fetch_addr_i  (fetch_addr_i),
`ifdef INSTR_ALIGNER_ERR_EN
        .fetch_err_i   (fetch_err_i),
        .instr_err_o   (instr_err),
`endif
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_addr_o  (instr_addr_o)
    );

`ifndef INSTR_ALIGNER_ERR_EN
    assign instr_err = 1'b0;
`endif

    // Reference model: the program as a stream of halfwords not yet delivered.
    typedef struct {
        logic [15:0] h;
        logic [31:0] a;
        logic        e;
    } hw_t;

    hw_t         mq[$];
    bit          skip;
    int          checks;
    int          errors;
    int          cyc;
    bit          last_push;
    bit          prev_stall;
    logic [31:0] prev_instr;
    logic [31:0] prev_addr;

    logic [31:0] got_instr[$];
    logic [31:0] got_addr[$];
    logic        got_err[$];
    int          got_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit avail();
        if (mq.size() == 0) return 1'b0;
        if (mq[0].h[1:0] != 2'b11) return 1'b1;
        return mq.size() >= 2;
    endfunction

    // One clock: check outputs mid-cycle, update the model, then advance past the edge.
    task automatic step();
        bit          xfer;
        bit          push;
        bit          is32;
        logic [31:0] ei;
        logic [31:0] ea;
        logic        ee;
        @(negedge clk);
        xfer = (instr_valid_o === 1'b1) && (instr_ready_i === 1'b1);
        push = fetch_valid_i && (fetch_ready_o === 1'b1) && !flush_i;
        if (flush_i) chk("flush_forces_invalid", 32'(instr_valid_o), 32'd0);
        if (prev_stall && !flush_i) begin
            chk("stall_valid_held", 32'(instr_valid_o), 32'd1);
            chk("stall_instr_held", instr_o, prev_instr);
            chk("stall_addr_held", instr_addr_o, prev_addr);
        end
        if (instr_valid_o === 1'b1) begin
            chk("valid_has_data", 32'(avail()), 32'd1);
            if (avail()) begin
                is32 = (mq[0].h[1:0] == 2'b11);
                ea   = mq[0].a;
                if (is32) begin
                    ei = {mq[1].h, mq[0].h};
                    ee = mq[0].e | mq[1].e;
                end else begin
                    ei = {16'h0, mq[0].h};
                    ee = mq[0].e;
                end
                if (ee) ei = 32'h0;
                chk("instr", instr_o, ei);
                chk("instr_addr", instr_addr_o, ea);
                chk("instr_err", 32'(instr_err), 32'(ee));
                if (xfer) begin
                    void'(mq.pop_front());
                    if (is32) void'(mq.pop_front());
                end
            end
        end
        if (xfer) begin
            got_instr.push_back(instr_o);
            got_addr.push_back(instr_addr_o);
            got_err.push_back(instr_err);
            got_cyc.push_back(cyc);
        end
        prev_stall = (instr_valid_o === 1'b1) && !instr_ready_i && !flush_i;
        prev_instr = instr_o;
        prev_addr  = instr_addr_o;
        if (flush_i) begin
            mq.delete();
            skip = flush_addr_i[1];
        end else if (push) begin
            if (!skip) mq.push_back('{fetch_rdata_i[15:0], {fetch_addr_i[31:2], 2'b00}, fetch_err_i & ERR_EN});
            mq.push_back('{fetch_rdata_i[31:16], {fetch_addr_i[31:2], 2'b10}, fetch_err_i & ERR_EN});
            skip = 1'b0;
        end
        last_push = push;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [31:0] a, input bit with_fetch);
        flush_i       = 1'b1;
        flush_addr_i  = a;
        fetch_valid_i = with_fetch;
        fetch_rdata_i = 32'hdeadbeef;
        fetch_addr_i  = a & ~32'h3;
        step();
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
    endtask

    task automatic offer(input logic [31:0] d, input logic [31:0] a, input logic e);
        bit acc;
        acc           = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = d;
        fetch_addr_i  = a;
        fetch_err_i   = e;
        for (int k = 0; k < 20 && !acc; k++) begin
            step();
            acc = last_push;
        end
        chk("offer_accepted", 32'(acc), 32'd1);
        fetch_valid_i = 1'b0;
        fetch_err_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        fetch_valid_i = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_log();
        got_instr.delete();
        got_addr.delete();
        got_err.delete();
        got_cyc.delete();
    endtask

    task automatic check_log_size(input string tag, input int n);
        chk(tag, 32'(got_instr.size()), 32'(n));
        while (got_instr.size() < n) begin
            got_instr.push_back('x);
            got_addr.push_back('x);
            got_err.push_back(1'bx);
            got_cyc.push_back(-1000);
        end
    endtask

    logic [31:0] bpw[4];
    logic [31:0] cur_word;
    logic [31:0] cur_addr;
    logic [31:0] fa;
    bit          have;
    int          idx;

    initial begin
        checks = 0; errors = 0; cyc = 0; skip = 1'b0; prev_stall = 1'b0;
        rst_i = 1'b1; flush_i = 1'b0; flush_addr_i = '0; fetch_valid_i = 1'b0;
        fetch_rdata_i = '0; fetch_addr_i = '0; fetch_err_i = 1'b0; instr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_fetch_ready", 32'(fetch_ready_o), 32'd1);
        chk("reset_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("reset_instr", instr_o, 32'h0);
        chk("reset_instr_addr", instr_addr_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Aligned 32-bit stream, no bubbles.
        instr_ready_i = 1'b1;
        do_flush(32'h100, 1'b0);
        clear_log();
        offer(32'h00000013, 32'h100, 1'b0);
        offer(32'h00100093, 32'h104, 1'b0);
        idle(3);
        check_log_size("aligned_count", 2);
        chk("aligned_i0", got_instr[0], 32'h00000013);
        chk("aligned_a0", got_addr[0], 32'h100);
        chk("aligned_i1", got_instr[1], 32'h00100093);
        chk("aligned_a1", got_addr[1], 32'h104);
        chk("aligned_no_bubble", 32'(got_cyc[1] - got_cyc[0]), 32'd1);

        // Two compressed instructions packed in one word.
        do_flush(32'h200, 1'b0);
        clear_log();
        offer(32'h45014501, 32'h200, 1'b0);
        idle(4);
        check_log_size("packed_count", 2);
        chk("packed_i0", got_instr[0], 32'h00004501);
        chk("packed_a0", got_addr[0], 32'h200);
        chk("packed_i1", got_instr[1], 32'h00004501);
        chk("packed_a1", got_addr[1], 32'h202);
        chk("packed_fifo_empty", 32'(fetch_ready_o), 32'd1);

        // 32-bit instruction split across two words, one bubble.
        do_flush(32'h300, 1'b0);
        clear_log();
        offer(32'h00134505, 32'h300, 1'b0);
        offer(32'h00930000, 32'h304, 1'b0);
        idle(5);
        check_log_size("split_count", 2);
        chk("split_i0", got_instr[0], 32'h00004505);
        chk("split_a0", got_addr[0], 32'h300);
        chk("split_i1", got_instr[1], 32'h00000013);
        chk("split_a1", got_addr[1], 32'h302);
        chk("split_one_bubble", 32'(got_cyc[1] - got_cyc[0]), 32'd2);
        chk("split_waits_next", 32'(instr_valid_o), 32'd0);

        // Flush to an upper halfword, with a response dropped in the flush cycle.
        clear_log();
        do_flush(32'h402, 1'b1);
        offer(32'h45051234, 32'h400, 1'b0);
        idle(4);
        check_log_size("flush_count", 1);
        chk("flush_i0", got_instr[0], 32'h00004505);
        chk("flush_a0", got_addr[0], 32'h402);

        // Backpressure fills the two-entry FIFO.
        bpw[0] = 32'h00000013; bpw[1] = 32'h00100093;
        bpw[2] = 32'h00200113; bpw[3] = 32'h00300193;
        do_flush(32'h500, 1'b0);
        clear_log();
        instr_ready_i = 1'b0;
        idx = 0;
        repeat (5) begin
            fetch_valid_i = 1'b1;
            fetch_rdata_i = bpw[idx];
            fetch_addr_i  = 32'h500 + 32'(idx * 4);
            step();
            if (last_push) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_ready_low", 32'(fetch_ready_o), 32'd0);
        chk("bp_head_instr", instr_o, 32'h00000013);
        instr_ready_i = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            fetch_valid_i = 1'b1;
            fetch_rdata_i = bpw[idx];
            fetch_addr_i  = 32'h500 + 32'(idx * 4);
            step();
            if (last_push) idx++;
        end
        idle(4);
        check_log_size("bp_count", 4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_instr_order", got_instr[k], bpw[k]);
            chk("bp_addr_order", got_addr[k], 32'h500 + 32'(k * 4));
        end

`ifdef INSTR_ALIGNER_ERR_EN
        // Split instruction whose second word is errored.
        do_flush(32'h600, 1'b0);
        clear_log();
        offer(32'h00134505, 32'h600, 1'b0);
        offer(32'h00930000, 32'h604, 1'b1);
        idle(4);
        check_log_size("err_count", 2);
        chk("err_first_clean", 32'(got_err[0]), 32'd0);
        chk("err_split_flag", 32'(got_err[1]), 32'd1);
        chk("err_split_instr", got_instr[1], 32'h0);
        chk("err_split_addr", got_addr[1], 32'h602);
`endif

        // Randomized traffic with random backpressure and occasional redirects.
        cur_addr = 32'h1000;
        have     = 1'b0;
        do_flush(cur_addr, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (!have) begin
                cur_word = $urandom;
                have     = 1'b1;
            end
            instr_ready_i = ($urandom % 4) != 0;
            fetch_err_i   = ($urandom % 16) == 0;
            if (($urandom % 64) == 0) begin
                fa = 32'h1000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom % 4);
                flush_i       = 1'b1;
                flush_addr_i  = fa;
                fetch_valid_i = $urandom % 2;
                fetch_rdata_i = cur_word;
                fetch_addr_i  = cur_addr;
                step();
                flush_i  = 1'b0;
                cur_addr = fa & ~32'h3;
                have     = 1'b0;
            end else begin
                fetch_valid_i = ($urandom % 4) != 0;
                fetch_rdata_i = cur_word;
                fetch_addr_i  = cur_addr | 32'($urandom % 4);
                step();
                if (last_push) begin
                    have     = 1'b0;
                    cur_addr = cur_addr + 32'd4;
                end
            end
        end
        fetch_valid_i = 1'b0;
        fetch_err_i   = 1'b0;
        instr_ready_i = 1'b1;
        for (int k = 0; k < 40 && avail(); k++) step();
        idle(2);
        chk("drain_model_empty", 32'(avail()), 32'd0);
        chk("drain_valid_low", 32'(instr_valid_o), 32'd0);

        // Asynchronous reset in the middle of operation.
        do_flush(32'h2000, 1'b0);
        instr_ready_i = 1'b0;
        offer(32'h00000013, 32'h2000, 1'b0);
        chk("pre_reset_valid", 32'(instr_valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_reset_valid", 32'(instr_valid_o), 32'd0);
        chk("async_reset_ready", 32'(fetch_ready_o), 32'd1);
        chk("async_reset_instr", instr_o, 32'h0);
        chk("async_reset_addr", instr_addr_o, 32'h0);
        mq.delete();
        skip       = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        instr_ready_i = 1'b1;
        clear_log();
        offer(32'h45014501, 32'h3000, 1'b0);
        idle(4);
        check_log_size("post_reset_count", 2);
        chk("post_reset_a0", got_addr[0], 32'h3000);
        chk("post_reset_a1", got_addr[1], 32'h3002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
